// File: rtl/times_table_arbiter_if.sv
// Bundle between the times-table arbiter, its two clients and the shared memory.
interface times_table_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 6
);
  logic                  req0;
  logic                  req1;
  logic [2:0]            a0;
  logic [2:0]            b0;
  logic [2:0]            a1;
  logic [2:0]            b1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  done0;
  logic                  done1;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  busy_o;
  logic                  mem_enable;
  logic [5:0]            mem_address;
  logic [DATA_WIDTH-1:0] mem_data;

  // Arbiter side.
  modport slave (
    input  req0, req1, a0, b0, a1, b1, mem_data,
    output gnt0, gnt1, done0, done1, result_o, busy_o, mem_enable, mem_address
  );

  // Client and memory side.
  modport master (
    output req0, req1, a0, b0, a1, b1, mem_data,
    input  gnt0, gnt1, done0, done1, result_o, busy_o, mem_enable, mem_address
  );
endinterface

// File: rtl/times_table_arbiter.sv
// Round-robin arbiter sharing one 8x8 times-table memory between two requesters.
// One operation at a time: grant, one-cycle memory strobe, fixed latency wait,
// capture, one-cycle done pulse.
module times_table_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned DATA_WIDTH  = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  times_table_arbiter_if.slave bus
);

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_issue = 2'd1;
  localparam logic [1:0] st_wait  = 2'd2;
  localparam logic [1:0] st_done  = 2'd3;

  // Counter reload so that capture lands MEM_LATENCY edges after the memory samples.
  localparam logic [1:0] lat_load = 2'(MEM_LATENCY - 1);

  logic [1:0]            state_q;
  logic [1:0]            cnt_q;
  logic                  owner_q;
  logic                  last_owner_q;
  logic                  gnt0_q;
  logic                  gnt1_q;
  logic                  done0_q;
  logic                  done1_q;
  logic                  busy_q;
  logic                  mem_enable_q;
  logic [5:0]            mem_address_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  win;

  // Winner of an IDLE sample: a lone requester always wins, a tie goes to the port
  // that was not served last.
  always_comb begin
    win = bus.req1;
    if (bus.req0 && bus.req1) begin
      win = ~last_owner_q;
    end
  end

  // Operation sequencer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= st_idle;
      cnt_q         <= 2'd0;
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      busy_q        <= 1'b0;
      mem_enable_q  <= 1'b0;
      mem_address_q <= 6'd0;
      result_q      <= '0;
    end else begin
      unique case (state_q)
        st_idle: begin
          if (bus.req0 || bus.req1) begin
            mem_address_q <= win ? {bus.a1, bus.b1} : {bus.a0, bus.b0};
            owner_q       <= win;
            last_owner_q  <= win;
            gnt0_q        <= ~win;
            gnt1_q        <= win;
            mem_enable_q  <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= st_issue;
          end
        end
        st_issue: begin
          gnt0_q       <= 1'b0;
          gnt1_q       <= 1'b0;
          mem_enable_q <= 1'b0;
          cnt_q        <= lat_load;
          state_q      <= st_wait;
        end
        st_wait: begin
          if (cnt_q == 2'd0) begin
            result_q <= bus.mem_data;
            done0_q  <= ~owner_q;
            done1_q  <= owner_q;
            state_q  <= st_done;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        st_done: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= st_idle;
        end
        default: state_q <= st_idle;
      endcase
    end
  end

  assign bus.gnt0        = gnt0_q;
  assign bus.gnt1        = gnt1_q;
  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.busy_o      = busy_q;
  assign bus.mem_enable  = mem_enable_q;
  assign bus.mem_address = mem_address_q;
  assign bus.result_o    = result_q;

endmodule

// File: tb/tb_times_table_arbiter.sv
// Bench for times_table_arbiter: a MEM_LATENCY=1 instance checked cycle by cycle
// against a transaction-level model, plus a MEM_LATENCY=3 instance checked directly.
module tb_times_table_arbiter;

  localparam int DW = 6;
  localparam int L1 = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  times_table_arbiter_if #(.DATA_WIDTH(DW)) bus1 ();
  times_table_arbiter_if #(.DATA_WIDTH(DW)) bus3 ();

  times_table_arbiter #(.MEM_LATENCY(1), .DATA_WIDTH(DW)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  times_table_arbiter #(.MEM_LATENCY(3), .DATA_WIDTH(DW)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  // Memory models: product valid for exactly one cycle, corrupted otherwise.
  function automatic logic [5:0] tbl(logic [5:0] ad);
    return 6'(int'(ad[5:3]) * int'(ad[2:0]));
  endfunction

  logic       v1 = 1'b0;
  logic [5:0] d1 = 6'd0;
  logic [5:0] j1 = 6'd1;
  always @(posedge clk) begin
    v1 <= bus1.mem_enable;
    d1 <= tbl(bus1.mem_address);
    j1 <= 6'(1 + $urandom_range(62));
  end
  assign bus1.mem_data = v1 ? d1 : (d1 ^ j1);

  logic [2:0] v3 = 3'd0;
  logic [5:0] d3 [3];
  logic [5:0] j3 = 6'd1;
  initial begin
    d3[0] = 6'd0;
    d3[1] = 6'd0;
    d3[2] = 6'd0;
  end
  always @(posedge clk) begin
    v3    <= {v3[1:0], bus3.mem_enable};
    d3[0] <= tbl(bus3.mem_address);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
    j3    <= 6'(1 + $urandom_range(62));
  end
  assign bus3.mem_data = v3[2] ? d3[2] : (d3[2] ^ j3);

  int checks   = 0;
  int failures = 0;

  // Transaction model of the L=1 instance, counted in edges since reset release.
  int edge_n;
  int m_next_sample;
  int m_gnt_edge;
  int m_done_edge;
  int m_addr;
  int m_pend;
  int m_result;
  bit m_owner;
  bit m_last;

  task automatic model_reset();
    edge_n        = 0;
    m_next_sample = 1;
    m_gnt_edge    = -100;
    m_done_edge   = -100;
    m_addr        = 0;
    m_pend        = 0;
    m_result      = 0;
    m_owner       = 1'b0;
    m_last        = 1'b1;
  endtask

  // Applies one edge using the inputs present at that edge.
  task automatic model_edge();
    bit w;
    edge_n++;
    if (edge_n == m_done_edge) m_result = m_pend;
    if (edge_n >= m_next_sample && (bus1.req0 || bus1.req1)) begin
      if (bus1.req0 && bus1.req1) w = !m_last;
      else w = bus1.req1;
      m_owner       = w;
      m_last        = w;
      m_gnt_edge    = edge_n;
      m_done_edge   = edge_n + L1 + 1;
      m_next_sample = edge_n + L1 + 3;
      if (w) begin
        m_addr = int'(bus1.a1) * 8 + int'(bus1.b1);
        m_pend = int'(bus1.a1) * int'(bus1.b1);
      end else begin
        m_addr = int'(bus1.a0) * 8 + int'(bus1.b0);
        m_pend = int'(bus1.a0) * int'(bus1.b0);
      end
    end
  endtask

  function automatic logic [17:0] exp1();
    logic ge;
    logic de;
    logic bz;
    ge = (edge_n == m_gnt_edge);
    de = (edge_n == m_done_edge);
    bz = (edge_n >= m_gnt_edge) && (edge_n <= m_done_edge);
    return {ge && !m_owner, ge && m_owner, de && !m_owner, de && m_owner, ge, bz,
            6'(m_addr), 6'(m_result)};
  endfunction

  function automatic logic [17:0] obs1();
    return {bus1.gnt0, bus1.gnt1, bus1.done0, bus1.done1, bus1.mem_enable, bus1.busy_o,
            bus1.mem_address, bus1.result_o};
  endfunction

  function automatic logic [17:0] obs3();
    return {bus3.gnt0, bus3.gnt1, bus3.done0, bus3.done1, bus3.mem_enable, bus3.busy_o,
            bus3.mem_address, bus3.result_o};
  endfunction

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(int n);
    bus1.req0 = 1'b0;
    bus1.req1 = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    bus1.req0 = 1'b1;
    bus1.req1 = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      if (obs1() !== 18'd0) begin
        failures++;
        $display("FAIL reset_l1 got=%h exp=%h", obs1(), 18'd0);
      end
      checks++;
      if (obs3() !== 18'd0) begin
        failures++;
        $display("FAIL reset_l3 got=%h exp=%h", obs3(), 18'd0);
      end
      checks++;
    end
    bus1.req0 = 1'b0;
    bus1.req1 = 1'b0;
    rst_n = 1'b1;
    model_reset();
    repeat (2) begin
      tick();
      if (obs1() !== exp1()) begin
        failures++;
        $display("FAIL post_reset got=%h exp=%h", obs1(), exp1());
      end
      checks++;
    end
  endtask

  task automatic test_single();
    bus1.a0   = 3'd3;
    bus1.b0   = 3'd5;
    bus1.req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obs1() !== exp1()) begin
        failures++;
        $display("FAIL single cyc=%0d got=%h exp=%h", i, obs1(), exp1());
      end
      checks++;
      if (edge_n == m_gnt_edge) bus1.req0 = 1'b0;
    end
    if (bus1.result_o !== 6'd15) begin
      failures++;
      $display("FAIL single_result got=%0d exp=15", bus1.result_o);
    end
    checks++;
  endtask

  task automatic test_tie_alternate();
    int g0;
    int g1;
    g0 = 0;
    g1 = 0;
    bus1.a0 = 3'd7;
    bus1.b0 = 3'd7;
    bus1.a1 = 3'd2;
    bus1.b1 = 3'd6;
    bus1.req0 = 1'b1;
    bus1.req1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (obs1() !== exp1()) begin
        failures++;
        $display("FAIL tie cyc=%0d got=%h exp=%h", i, obs1(), exp1());
      end
      checks++;
      g0 += int'(bus1.gnt0);
      g1 += int'(bus1.gnt1);
    end
    if (g0 != 2 || g1 != 2) begin
      failures++;
      $display("FAIL tie_counts got=%0d/%0d exp=2/2", g0, g1);
    end
    checks++;
  endtask

  task automatic test_lone_req1();
    int g1;
    g1 = 0;
    bus1.a1   = 3'd4;
    bus1.b1   = 3'd0;
    bus1.req1 = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (obs1() !== exp1()) begin
        failures++;
        $display("FAIL lone cyc=%0d got=%h exp=%h", i, obs1(), exp1());
      end
      checks++;
      g1 += int'(bus1.gnt1);
    end
    if (g1 != 4) begin
      failures++;
      $display("FAIL lone_count got=%0d exp=4", g1);
    end
    checks++;
    if (bus1.result_o !== 6'd0) begin
      failures++;
      $display("FAIL lone_result got=%0d exp=0", bus1.result_o);
    end
    checks++;
  endtask

  task automatic test_latency3();
    logic [17:0] e;
    bus3.a0   = 3'd6;
    bus3.b0   = 3'd5;
    bus3.req0 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      e = {c == 1, 1'b0, c == 5, 1'b0, c == 1, (c >= 1 && c <= 5), 6'd53,
           (c >= 5) ? 6'd30 : 6'd0};
      if (obs3() !== e) begin
        failures++;
        $display("FAIL lat3 cyc=%0d got=%h exp=%h", c, obs3(), e);
      end
      checks++;
      if (c == 1) begin
        bus3.req0 = 1'b0;
        bus3.a0   = 3'd1;
        bus3.b0   = 3'd1;
      end
    end
  endtask

  task automatic test_random();
    bit         rq [2];
    logic [2:0] ra [2];
    logic [2:0] rb [2];
    bit         granted;
    rq[0] = 1'b0;
    rq[1] = 1'b0;
    ra[0] = 3'd0;
    ra[1] = 3'd0;
    rb[0] = 3'd0;
    rb[1] = 3'd0;
    for (int i = 0; i < 240; i++) begin
      for (int p = 0; p < 2; p++) begin
        granted = (edge_n == m_gnt_edge) && (int'(m_owner) == p);
        if (rq[p]) begin
          if (granted) begin
            rq[p] = ($urandom_range(1) == 1);
            ra[p] = 3'($urandom_range(7));
            rb[p] = 3'($urandom_range(7));
          end else if ($urandom_range(7) == 0) begin
            rq[p] = 1'b0;
          end
        end else if ($urandom_range(2) == 0) begin
          rq[p] = 1'b1;
          ra[p] = 3'($urandom_range(7));
          rb[p] = 3'($urandom_range(7));
        end
      end
      bus1.req0 = rq[0];
      bus1.a0   = ra[0];
      bus1.b0   = rb[0];
      bus1.req1 = rq[1];
      bus1.a1   = ra[1];
      bus1.b1   = rb[1];
      tick();
      if (obs1() !== exp1()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs1(), exp1());
      end
      checks++;
    end
  endtask

  task automatic test_operand_change();
    bus1.a0   = 3'd2;
    bus1.b0   = 3'd3;
    bus1.req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obs1() !== exp1()) begin
        failures++;
        $display("FAIL opchg cyc=%0d got=%h exp=%h", i, obs1(), exp1());
      end
      checks++;
      if (edge_n == m_gnt_edge) begin
        bus1.req0 = 1'b0;
        bus1.a0   = 3'd7;
        bus1.b0   = 3'd7;
      end
    end
    if (bus1.result_o !== 6'd6) begin
      failures++;
      $display("FAIL opchg_result got=%0d exp=6", bus1.result_o);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    bus1.a0   = 3'd5;
    bus1.b0   = 3'd5;
    bus1.req0 = 1'b1;
    tick();
    bus1.req0 = 1'b0;
    tick();
    if (obs1() !== exp1()) begin
      failures++;
      $display("FAIL mid_wait got=%h exp=%h", obs1(), exp1());
    end
    checks++;
    rst_n = 1'b0;
    #1;
    if (obs1() !== 18'd0) begin
      failures++;
      $display("FAIL mid_async_reset got=%h exp=%h", obs1(), 18'd0);
    end
    checks++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (obs1() !== exp1()) begin
        failures++;
        $display("FAIL mid_after cyc=%0d got=%h exp=%h", i, obs1(), exp1());
      end
      checks++;
    end
    bus1.a0   = 3'd7;
    bus1.b0   = 3'd7;
    bus1.a1   = 3'd2;
    bus1.b1   = 3'd6;
    bus1.req0 = 1'b1;
    bus1.req1 = 1'b1;
    tick();
    if (bus1.gnt0 !== 1'b1 || bus1.gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL mid_first_tie got=%b%b exp=10", bus1.gnt0, bus1.gnt1);
    end
    checks++;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs1() !== exp1()) begin
        failures++;
        $display("FAIL mid_tie cyc=%0d got=%h exp=%h", i, obs1(), exp1());
      end
      checks++;
    end
  endtask

  initial begin
    bus1.req0 = 1'b0;
    bus1.req1 = 1'b0;
    bus1.a0   = 3'd0;
    bus1.b0   = 3'd0;
    bus1.a1   = 3'd0;
    bus1.b1   = 3'd0;
    bus3.req0 = 1'b0;
    bus3.req1 = 1'b0;
    bus3.a0   = 3'd0;
    bus3.b0   = 3'd0;
    bus3.a1   = 3'd0;
    bus3.b1   = 3'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    idle(6);
    test_tie_alternate();
    idle(6);
    test_lone_req1();
    idle(6);
    test_latency3();
    idle(2);
    test_random();
    idle(6);
    test_operand_change();
    idle(2);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/times_table_arbiter.md
# times_table_arbiter

Shares a single times-table memory (64 entries, entry {a,b} holds a×b for a,b in 0..7) between two requesters. Each requester presents operands and a request; the block arbitrates round-robin, drives the memory's enable/address port for one cycle, waits a fixed read latency, captures the product and returns it with a one-cycle done pulse. It sits between the memory and two independent clients that would otherwise each need their own copy of the table.

## Interface
- MEM_LATENCY, default 1: edges from the memory sampling enable/address to mem_data being valid; legal 1..4.
- DATA_WIDTH, default 6: product width; must hold 49.
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  operation request from port 0 / port 1.
- a0, b0 / a1, b1  in  3 each  operands; must be stable while req is high and not yet granted.
- gnt0 / gnt1  out  1  registered one-cycle pulse: operands of that port captured this cycle.
- done0 / done1  out  1  registered one-cycle pulse: result_o valid for that port.
- result_o  out  DATA_WIDTH  last captured product; holds between operations.
- busy_o  out  1  high in every state except IDLE.
- mem_enable  out  1  read strobe to memory, high exactly one cycle per operation.
- mem_address  out  6  {a,b} of the granted port (a×8+b).
- mem_data  in  DATA_WIDTH  memory read data.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample req0/req1 each edge. None -> stay. Exactly one -> grant it. Both -> grant the port not equal to last_owner.
- On grant edge: latch mem_address <= {a,b} of winner; owner <= winner; last_owner <= winner; gnt<winner> <= 1; mem_enable <= 1; state -> ISSUE.
- ISSUE (one cycle, gnt and mem_enable high): next edge clears gnt/mem_enable, loads latency counter with MEM_LATENCY-1, state -> WAIT.
- WAIT: decrement counter each edge; on the edge where counter is 0, result_o <= mem_data, done<owner> <= 1, state -> DONE.
- DONE (one cycle, done high): next edge clears done, state -> IDLE.
- Requests are sampled only in IDLE; a req held through DONE is treated as a new request (back-to-back allowed). A req dropped before the IDLE sample is never granted.
- Operands may change any time after the gnt cycle; latched address is used.
- mem_address holds its last value outside ISSUE.
- Reset (any state, including mid-operation): state IDLE, gnt0/gnt1/done0/done1/mem_enable/busy_o = 0, mem_address = 0, result_o = 0, counter = 0, last_owner = 1 (port 0 wins the first tie). In-flight operation is discarded; no done is produced for it.

## Timing
- Request high before edge E1 in IDLE: gnt and mem_enable high during cycle after E1.
- Memory samples at E2; data valid after E(2+MEM_LATENCY) capture point; done and result_o valid in the cycle after edge E(2+MEM_LATENCY).
- Request-to-done latency: MEM_LATENCY+2 edges; earliest next grant one edge after DONE, giving one operation per MEM_LATENCY+3 cycles.
- At most one of gnt0/gnt1 and at most one of done0/done1 high in any cycle; gnt and done never overlap.
- All outputs are registered; no combinational path from req/a/b to any output.

## Test plan
- Reset, then req0 with a0=3, b0=5 (MEM_LATENCY=1): gnt0 one cycle, mem_address=29, mem_enable one cycle, done0 three edges after sample, result_o=15, done1/gnt1 never high.
- req0 and req1 asserted together after reset, held continuously, a0=7,b0=7, a1=2,b1=6: grants alternate 0,1,0,1...; results 49,12,49,12; each done on its own port; no two gnt/done pulses of different ports overlap.
- Only req1 held continuously (a1=4,b1=0): port 1 granted every MEM_LATENCY+3 cycles, result_o=0, round-robin does not block a lone requester.
- MEM_LATENCY=3, a0=6,b0=5: done0 five edges after request sample, result_o=30; mem_data changes before capture point are ignored.
- Assert rst_n low during WAIT of a port-0 operation: all outputs go to reset values immediately; after release no done0 for that operation; next req1 tie with req0 grants port 0 first.
- Change a0/b0 in the cycle after gnt0: result_o reflects the operands present at grant, not the new ones.
